// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 pattern source (x^31 + x^28 + 1).
package prbs31_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOP       = 2'b00;
    localparam logic [1:0] OP_LOAD_SEED = 2'b01;
    localparam logic [1:0] OP_START     = 2'b10;
    localparam logic [1:0] OP_STOP      = 2'b11;

    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;

    localparam logic [30:0] SEED_DEFAULT = 31'h7FFF_FFFF;

    function automatic logic [30:0] lfsr_next(input logic [30:0] v);
        return {v[29:0], v[TAP_HI] ^ v[TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs31_lfsr.sv
// 31-bit Fibonacci LFSR with seed load; an all-zero seed would lock up, so it is replaced.
module prbs31_lfsr
    import prbs31_pkg::*;
#(
    parameter logic [30:0] SEED_INIT = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [30:0] seed,
    input  logic        advance,
    output logic        lfsr_bit
);

    logic [30:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            lfsr_q <= SEED_INIT;
        end else if (load) begin
            lfsr_q <= (seed == 31'd0) ? SEED_INIT : seed;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr_bit = lfsr_q[TAP_HI];

endmodule

// File: rtl/prbs31_ctrl.sv
// PRBS31 burst controller: command port, IDLE/RUN sequencing, burst counters and status pulses.
module prbs31_ctrl
    import prbs31_pkg::*;
#(
    parameter int          BURST_W      = 16,
    parameter logic [30:0] SEED_DEFAULT = prbs31_pkg::SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [30:0]        cmd_seed,
    input  logic [BURST_W-1:0] cmd_len,
    output logic               prbs_bit,
    output logic               prbs_valid,
    input  logic               prbs_ready,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cmd_err,
    output logic [BURST_W-1:0] bit_count,
    output state_t             dbg_state
);

    // Handshakes: a command is taken on any edge where cmd_valid & cmd_ready,
    // a bit is taken on any edge where prbs_valid & prbs_ready.
    state_t             state;
    logic [BURST_W-1:0] remaining;
    logic               cmd_fire;
    logic               xfer;
    logic               final_xfer;
    logic               lfsr_load;

    assign cmd_ready  = ~rst_n;
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign xfer       = prbs_valid & prbs_ready;
    assign final_xfer = xfer && (remaining == BURST_W'(1));
    assign lfsr_load  = cmd_fire && (state == ST_IDLE) && (cmd_op == OP_LOAD_SEED);
    assign dbg_state  = state;

    prbs31_lfsr #(
        .SEED_INIT (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .seed     (cmd_seed),
        .advance  (xfer),
        .lfsr_bit (prbs_bit)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            bit_count  <= '0;
            prbs_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire && cmd_op == OP_START) begin
                        remaining  <= cmd_len;
                        bit_count  <= '0;
                        prbs_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        bit_count <= bit_count + BURST_W'(1);
                        if (remaining != '0) begin
                            remaining <= remaining - BURST_W'(1);
                        end
                    end
                    if (cmd_fire && (cmd_op == OP_LOAD_SEED || cmd_op == OP_START)) begin
                        cmd_err <= 1'b1;
                    end
                    // A completing transfer outranks a same-cycle STOP.
                    if (final_xfer) begin
                        prbs_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (cmd_fire && cmd_op == OP_STOP) begin
                        prbs_valid <= 1'b0;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs31_ctrl.sv
// Bench for prbs31_ctrl: directed bursts, expected bits/events queued, checked by a monitor.
module tb_prbs31_ctrl;
    import prbs31_pkg::*;

    localparam logic [1:0] C_NOP   = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_START = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [30:0] cmd_seed;
    logic [15:0] cmd_len;
    logic        prbs_bit;
    logic        prbs_valid;
    logic        prbs_ready;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        cmd_err;
    logic [15:0] bit_count;
    state_t      dbg_state;

    prbs31_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_seed   (cmd_seed),
        .cmd_len    (cmd_len),
        .prbs_bit   (prbs_bit),
        .prbs_valid (prbs_valid),
        .prbs_ready (prbs_ready),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .cmd_err    (cmd_err),
        .bit_count  (bit_count),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    int          ev_seen  = 0;
    int          cyc      = 0;
    int          last_xfer_cyc = -10;
    logic [30:0] m_lfsr;
    logic [0:0]  exp_q[$];
    logic [18:0] exp_ev_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_lfsr = {m_lfsr[29:0], m_lfsr[30] ^ m_lfsr[27]};
    endtask

    // Hand-computed constant bits; the model is stepped alongside to stay in sync.
    task automatic push_const(input logic b, input int n);
        repeat (n) begin
            exp_q.push_back(b);
            model_step();
        end
    endtask

    task automatic push_model(input int n);
        repeat (n) begin
            exp_q.push_back(m_lfsr[30]);
            model_step();
        end
    endtask

    task automatic push_ev(input logic [2:0] code, input logic [15:0] cnt);
        exp_ev_q.push_back({code, cnt});
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [30:0] seed, input logic [15:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_seed  = seed;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = C_NOP;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        while (xfer_cnt < target && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (xfer_cnt < target) check("timeout_xfers", xfer_cnt, target);
    endtask

    task automatic wait_events(input int target, input int budget);
        while (ev_seen < target && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (ev_seen < target) check("timeout_events", ev_seen, target);
    endtask

    // Monitor: consumes expected bits on every transfer and expected events on every pulse.
    always @(negedge clk) begin
        logic [0:0]  eb;
        logic [18:0] ee;
        cyc++;
        if (!rst_n) begin
            if (prbs_valid && prbs_ready) begin
                if (exp_q.size() == 0) begin
                    check("bit_unexpected", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    check("prbs_bit", prbs_bit, eb);
                end
                last_xfer_cyc = cyc;
                xfer_cnt++;
            end
            if (done || aborted || cmd_err) begin
                ev_seen++;
                if (exp_ev_q.size() == 0) begin
                    check("event_unexpected", {done, aborted, cmd_err}, 0);
                end else begin
                    ee = exp_ev_q.pop_front();
                    check("event_kind", {done, aborted, cmd_err}, ee[18:16]);
                    check("event_bit_count", bit_count, ee[15:0]);
                    if (done || aborted) begin
                        check("end_after_last_xfer", last_xfer_cyc, cyc - 1);
                        check("end_valid_low", prbs_valid, 0);
                        check("end_busy_low", busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst_n      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = C_NOP;
        cmd_seed   = '0;
        cmd_len    = '0;
        prbs_ready = 1'b1;
        m_lfsr     = 31'h7FFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("cmd_ready_in_reset", cmd_ready, 0);
        check("reset_valid", prbs_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_pulses", {done, aborted, cmd_err}, 0);
        check("reset_bit_count", bit_count, 0);
        check("reset_state", dbg_state, ST_IDLE);
        rst_n = 1'b0;
        #1;
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Default seed: 31 ones, then nine zeros (feedback 1^1 until bit 60).
        send_cmd(C_START, '0, 16'd40);
        check("start_valid", prbs_valid, 1);
        check("start_busy", busy, 1);
        push_const(1'b1, 31);
        push_const(1'b0, 9);
        push_ev(3'b100, 16'd40);
        wait_events(1, 100);

        // Seed 1: thirty zeros then a one.
        send_cmd(C_LOAD, 31'h1, '0);
        m_lfsr = 31'h1;
        send_cmd(C_START, '0, 16'd31);
        push_const(1'b0, 30);
        push_const(1'b1, 1);
        push_ev(3'b100, 16'd31);
        wait_events(2, 100);

        // Zero seed falls back to the default.
        send_cmd(C_LOAD, 31'h0, '0);
        m_lfsr = 31'h7FFF_FFFF;
        send_cmd(C_START, '0, 16'd31);
        push_const(1'b1, 31);
        push_ev(3'b100, 16'd31);
        wait_events(3, 100);

        // Backpressure: ready alternates, sequence continues from the retained LFSR.
        send_cmd(C_START, '0, 16'd10);
        push_model(10);
        push_ev(3'b100, 16'd10);
        begin
            int budget = 100;
            while (ev_seen < 4 && budget > 0) begin
                prbs_ready = ~prbs_ready;
                @(posedge clk);
                #1;
                budget--;
            end
            prbs_ready = 1'b1;
            if (ev_seen < 4) check("timeout_toggle", ev_seen, 4);
        end

        // START during RUN is rejected and the burst carries on.
        send_cmd(C_START, '0, 16'd12);
        base = xfer_cnt;
        push_model(12);
        push_ev(3'b001, 16'd4);
        push_ev(3'b100, 16'd12);
        wait_xfers(base + 3, 50);
        send_cmd(C_START, '0, 16'd5);
        wait_events(6, 100);

        // STOP coinciding with the last bounded transfer reports done only.
        send_cmd(C_START, '0, 16'd6);
        base = xfer_cnt;
        push_model(6);
        push_ev(3'b100, 16'd6);
        wait_xfers(base + 5, 50);
        send_cmd(C_STOP, '0, '0);
        wait_events(7, 50);

        // Reset mid-burst: no pulse, everything back to reset values.
        send_cmd(C_START, '0, 16'd20);
        base = xfer_cnt;
        push_model(5);
        wait_xfers(base + 5, 50);
        prbs_ready = 1'b0;
        rst_n      = 1'b1;
        #1;
        check("cmd_ready_mid_reset", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        prbs_ready = 1'b1;
        check("midrst_valid", prbs_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bit_count", bit_count, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        m_lfsr = 31'h7FFF_FFFF;
        send_cmd(C_START, '0, 16'd32);
        push_const(1'b1, 31);
        push_const(1'b0, 1);
        push_ev(3'b100, 16'd32);
        wait_events(8, 100);

        // Continuous burst past the counter wrap, ended by STOP.
        send_cmd(C_START, '0, 16'd0);
        base = xfer_cnt;
        push_model(70000);
        push_ev(3'b010, 16'd4464);
        wait_xfers(base + 69999, 71000);
        send_cmd(C_STOP, '0, '0);
        wait_events(9, 50);
        repeat (3) @(posedge clk);
        #1;

        check("bits_left", exp_q.size(), 0);
        check("events_left", exp_ev_q.size(), 0);
        check("final_state", dbg_state, ST_IDLE);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
